// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: shared widths, branch funct3 codes, result_src encodings and ALU flag positions
package riscv_pipe_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int CNT_W      = 32;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_C = 3;
endpackage

// File: rtl/ex_mem_stage_branch_cond.sv
// branch_cond_unit: decodes funct3 against SUB flags {C,V,N,Z} into a taken decision
module branch_cond_unit
    import riscv_pipe_pkg::*;
(
    input  logic [2:0] i_funct3,
    input  logic [3:0] i_flags,
    output logic       o_taken
);
    logic w_z;
    logic w_lt;
    logic w_c;
    assign w_z  = i_flags[FLAG_Z];
    assign w_lt = i_flags[FLAG_N] ^ i_flags[FLAG_V];
    assign w_c  = i_flags[FLAG_C];
    // Carry set means no borrow, so it encodes unsigned A >= B; 010/011 fall through to not taken
    always_comb begin
        o_taken = (i_funct3 == F3_BEQ)  ? w_z   :
                  (i_funct3 == F3_BNE)  ? ~w_z  :
                  (i_funct3 == F3_BLT)  ? w_lt  :
                  (i_funct3 == F3_BGE)  ? ~w_lt :
                  (i_funct3 == F3_BLTU) ? ~w_c  :
                  (i_funct3 == F3_BGEU) ? w_c   : 1'b0;
    end
endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: branch/jump resolution and EX/MEM pipeline register; EX_MEM_BRANCH_STATS_EN adds saturating branch counters
module ex_mem_stage
    import riscv_pipe_pkg::*;
#(
    parameter int XLEN       = riscv_pipe_pkg::XLEN,
    parameter int REG_ADDR_W = riscv_pipe_pkg::REG_ADDR_W,
    parameter int CNT_W      = riscv_pipe_pkg::CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_e,
    input  logic [XLEN-1:0]       alu_result_e,
    input  logic [3:0]            flags_e,
    input  logic [XLEN-1:0]       write_data_e,
    input  logic [XLEN-1:0]       pc_e,
    input  logic [XLEN-1:0]       imm_ext_e,
    input  logic [REG_ADDR_W-1:0] rd_e,
    input  logic [2:0]            funct3_e,
    input  logic                  reg_write_e,
    input  logic                  mem_write_e,
    input  logic [1:0]            result_src_e,
    input  logic                  branch_e,
    input  logic                  jump_e,
    input  logic                  jalr_e,
    input  logic                  stall_m,
    input  logic                  flush_m,
    output logic                  pc_src_e,
    output logic [XLEN-1:0]       pc_target_e,
    output logic                  valid_m,
    output logic [XLEN-1:0]       alu_result_m,
    output logic [XLEN-1:0]       write_data_m,
    output logic [XLEN-1:0]       pc_plus4_m,
    output logic [REG_ADDR_W-1:0] rd_m,
    output logic                  reg_write_m,
    output logic                  mem_write_m,
`ifdef EX_MEM_BRANCH_STATS_EN
    output logic [CNT_W-1:0]      branch_count,
    output logic [CNT_W-1:0]      taken_count,
`endif
    output logic [1:0]            result_src_m
);
    logic                  w_taken;
    logic                  w_capture;
    logic                  r_valid;
    logic [XLEN-1:0]       r_alu_result;
    logic [XLEN-1:0]       r_write_data;
    logic [XLEN-1:0]       r_pc_plus4;
    logic [REG_ADDR_W-1:0] r_rd;
    logic                  r_reg_write;
    logic                  r_mem_write;
    logic [1:0]            r_result_src;

    branch_cond_unit u_cond (
        .i_funct3 (funct3_e),
        .i_flags  (flags_e),
        .o_taken  (w_taken)
    );

    assign w_capture = ~stall_m & ~flush_m;

    // Redirect is resolved in EX and does not wait on a MEM stall
    always_comb begin
        pc_src_e    = valid_e & ~flush_m & ((branch_e & w_taken) | jump_e);
        pc_target_e = jalr_e ? {alu_result_e[XLEN-1:1], 1'b0} : pc_e + imm_ext_e;
    end

    // EX/MEM register: flush inserts a bubble, stall holds, otherwise capture with side effects gated by valid_e
    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush_m) begin
            r_valid      <= 1'b0;
            r_alu_result <= '0;
            r_write_data <= '0;
            r_pc_plus4   <= '0;
            r_rd         <= '0;
            r_reg_write  <= 1'b0;
            r_mem_write  <= 1'b0;
            r_result_src <= '0;
        end else if (!stall_m) begin
            r_valid      <= valid_e;
            r_alu_result <= alu_result_e;
            r_write_data <= write_data_e;
            r_pc_plus4   <= pc_e + XLEN'(4);
            r_rd         <= rd_e;
            r_reg_write  <= reg_write_e & valid_e;
            r_mem_write  <= mem_write_e & valid_e;
            r_result_src <= result_src_e;
        end
    end

    assign valid_m      = r_valid;
    assign alu_result_m = r_alu_result;
    assign write_data_m = r_write_data;
    assign pc_plus4_m   = r_pc_plus4;
    assign rd_m         = r_rd;
    assign reg_write_m  = r_reg_write;
    assign mem_write_m  = r_mem_write;
    assign result_src_m = r_result_src;

`ifdef EX_MEM_BRANCH_STATS_EN
    logic [CNT_W-1:0] r_branch_count;
    logic [CNT_W-1:0] r_taken_count;
    logic             w_br_ev;
    assign w_br_ev = w_capture & valid_e & branch_e;
    // Saturating counters of captured branches and of those taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_branch_count <= '0;
            r_taken_count  <= '0;
        end else begin
            if (w_br_ev && r_branch_count != '1)
                r_branch_count <= r_branch_count + CNT_W'(1);
            if (w_br_ev && w_taken && r_taken_count != '1)
                r_taken_count <= r_taken_count + CNT_W'(1);
        end
    end
    assign branch_count = r_branch_count;
    assign taken_count  = r_taken_count;
`else
    logic w_unused;
    assign w_unused = w_capture;
`endif
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: scoreboard bench with random and directed stimulus; define EX_MEM_BRANCH_STATS_EN to also check counters
module tb_ex_mem_stage;
    import riscv_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_e, reg_write_e, mem_write_e, branch_e, jump_e, jalr_e, stall_m, flush_m;
    logic [31:0] alu_result_e, write_data_e, pc_e, imm_ext_e;
    logic [3:0]  flags_e;
    logic [4:0]  rd_e;
    logic [2:0]  funct3_e;
    logic [1:0]  result_src_e;
    logic        pc_src_e, valid_m, reg_write_m, mem_write_m;
    logic [31:0] pc_target_e, alu_result_m, write_data_m, pc_plus4_m;
    logic [4:0]  rd_m;
    logic [1:0]  result_src_m;
`ifdef EX_MEM_BRANCH_STATS_EN
    logic [31:0] branch_count, taken_count;
`endif

    ex_mem_stage dut (
        .clk(clk), .rst(rst), .valid_e(valid_e), .alu_result_e(alu_result_e), .flags_e(flags_e),
        .write_data_e(write_data_e), .pc_e(pc_e), .imm_ext_e(imm_ext_e), .rd_e(rd_e),
        .funct3_e(funct3_e), .reg_write_e(reg_write_e), .mem_write_e(mem_write_e),
        .result_src_e(result_src_e), .branch_e(branch_e), .jump_e(jump_e), .jalr_e(jalr_e),
        .stall_m(stall_m), .flush_m(flush_m), .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
        .valid_m(valid_m), .alu_result_m(alu_result_m), .write_data_m(write_data_m),
        .pc_plus4_m(pc_plus4_m), .rd_m(rd_m), .reg_write_m(reg_write_m), .mem_write_m(mem_write_m),
`ifdef EX_MEM_BRANCH_STATS_EN
        .branch_count(branch_count), .taken_count(taken_count),
`endif
        .result_src_m(result_src_m)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic valid; logic [31:0] alu, wd, pc, imm; logic [4:0] rd; logic [2:0] f3;
        logic [3:0] flags; logic rw, mw; logic [1:0] rs; logic br, j, jr, stall, flush;
    } stim_t;
    typedef struct {
        logic valid; logic [31:0] alu, wd, pc4; logic [4:0] rd; logic rw, mw; logic [1:0] rs;
        int bc, tc;
    } mst_t;

    mst_t model;
    mst_t mon_e;
    mst_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares the registered MEM view against the oldest expected state
    always @(posedge clk) begin
        #2;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("valid_m", 32'(valid_m), 32'(mon_e.valid));
            chk("alu_result_m", alu_result_m, mon_e.alu);
            chk("write_data_m", write_data_m, mon_e.wd);
            chk("pc_plus4_m", pc_plus4_m, mon_e.pc4);
            chk("rd_m", 32'(rd_m), 32'(mon_e.rd));
            chk("reg_write_m", 32'(reg_write_m), 32'(mon_e.rw));
            chk("mem_write_m", 32'(mem_write_m), 32'(mon_e.mw));
            chk("result_src_m", 32'(result_src_m), 32'(mon_e.rs));
`ifdef EX_MEM_BRANCH_STATS_EN
            chk("branch_count", branch_count, 32'(mon_e.bc));
            chk("taken_count", taken_count, 32'(mon_e.tc));
`endif
        end
    end

    function automatic stim_t blank();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic void zero_model();
        model = '{default: '0};
    endfunction

    // Drive one EX instruction, check the same-cycle redirect, and queue the post-edge expectation
    task automatic step(input stim_t s, input bit tk);
        @(negedge clk);
        valid_e = s.valid; alu_result_e = s.alu; write_data_e = s.wd; pc_e = s.pc; imm_ext_e = s.imm;
        rd_e = s.rd; funct3_e = s.f3; flags_e = s.flags; reg_write_e = s.rw; mem_write_e = s.mw;
        result_src_e = s.rs; branch_e = s.br; jump_e = s.j; jalr_e = s.jr; stall_m = s.stall; flush_m = s.flush;
        #1;
        chk("pc_src_e", 32'(pc_src_e), 32'(s.valid & ~s.flush & ((s.br & tk) | s.j)));
        chk("pc_target_e", pc_target_e, s.jr ? (s.alu & 32'hFFFF_FFFE) : s.pc + s.imm);
        if (!s.stall && !s.flush && s.valid && s.br) begin
            model.bc++;
            if (tk) model.tc++;
        end
        if (s.flush) begin
            model.valid = 0; model.alu = 0; model.wd = 0; model.pc4 = 0; model.rd = 0;
            model.rw = 0; model.mw = 0; model.rs = 0;
        end else if (!s.stall) begin
            model.valid = s.valid; model.alu = s.alu; model.wd = s.wd; model.pc4 = s.pc + 4;
            model.rd = s.rd; model.rw = s.rw & s.valid; model.mw = s.mw & s.valid; model.rs = s.rs;
        end
        q.push_back(model);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid_m"}, 32'(valid_m), 0);
        chk({tag, "_alu_m"}, alu_result_m, 0);
        chk({tag, "_pc4_m"}, pc_plus4_m, 0);
        chk({tag, "_rw_m"}, 32'({reg_write_m, mem_write_m, result_src_m, rd_m}), 0);
        chk({tag, "_wd_m"}, write_data_m, 0);
        chk({tag, "_pc_src"}, 32'(pc_src_e), 0);
`ifdef EX_MEM_BRANCH_STATS_EN
        chk({tag, "_counts"}, branch_count | taken_count, 0);
`endif
    endtask

    // Random instruction whose flags come from a real subtraction; taken is judged by plain comparisons
    task automatic rand_step();
        stim_t s;
        logic [31:0] a, b, d;
        bit tk;
        s = blank();
        a = $urandom;
        b = ($urandom_range(0, 3) == 0) ? a : $urandom;
        if ($urandom_range(0, 3) == 0) b = {~a[31], a[30:0]} ^ 32'($urandom_range(0, 3));
        d = a - b;
        s.flags = {a >= b, (a[31] ^ b[31]) & (d[31] ^ a[31]), d[31], d == 0};
        s.f3 = 3'($urandom_range(0, 7));
        case (s.f3)
            3'b000: tk = (a == b);
            3'b001: tk = (a != b);
            3'b100: tk = ($signed(a) < $signed(b));
            3'b101: tk = ($signed(a) >= $signed(b));
            3'b110: tk = (a < b);
            3'b111: tk = (a >= b);
            default: tk = 0;
        endcase
        s.valid = ($urandom_range(0, 7) != 0);
        s.br = $urandom_range(0, 1); s.j = ($urandom_range(0, 4) == 0) & ~s.br; s.jr = s.j & $urandom_range(0, 1);
        s.alu = s.jr ? $urandom : d;
        s.wd = $urandom; s.pc = $urandom; s.imm = $urandom; s.rd = 5'($urandom);
        s.rw = $urandom_range(0, 1); s.mw = $urandom_range(0, 1); s.rs = 2'($urandom_range(0, 2));
        s.stall = ($urandom_range(0, 7) == 0); s.flush = ($urandom_range(0, 9) == 0);
        step(s, tk);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        q.delete();
        rst = 1; stall_m = 1; valid_e = 0;
        #1;
        chk_all_zero("async_rst");
        @(negedge clk);
        chk_all_zero("rst_stall");
        rst = 0; stall_m = 0;
        zero_model();
    endtask

    initial begin
        stim_t s;
        rst = 1;
        {valid_e, reg_write_e, mem_write_e, branch_e, jump_e, jalr_e, stall_m, flush_m} = '0;
        {alu_result_e, write_data_e, pc_e, imm_ext_e} = '0;
        flags_e = 0; rd_e = 0; funct3_e = 0; result_src_e = 0;
        zero_model();
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 0;

        s = blank(); s.valid = 1; s.br = 1; s.f3 = F3_BEQ; s.flags = 4'b0001; s.pc = 32'h100; s.imm = 32'h20;
        s.rd = 5'd3; s.rw = 1;
        step(s, 1);
        s.flags = 4'b0000; step(s, 0);
        s.f3 = F3_BLT; s.flags = 4'b0010; step(s, 1);
        s.f3 = F3_BGEU; s.flags = 4'b1000; s.mw = 1; step(s, 1);
        s.f3 = 3'b010; s.flags = 4'b1111; step(s, 0);

        s = blank(); s.valid = 1; s.j = 1; s.jr = 1; s.alu = 32'h2003; s.pc = 32'h400; s.imm = 32'h80;
        s.rs = RES_PC4; s.rw = 1; s.rd = 5'd1; s.wd = 32'hDEAD_BEEF;
        step(s, 0);
        s = blank(); s.valid = 1; s.stall = 1; s.alu = 32'h1111; s.pc = 32'h900; s.rw = 1; s.rd = 5'd7;
        s.br = 1; s.f3 = F3_BNE; s.flags = 4'b0000;
        step(s, 1);
        s.alu = 32'h2222; step(s, 1);
        s.flush = 1; step(s, 1);
        s = blank(); s.valid = 0; s.rw = 1; s.mw = 1; s.pc = 32'h40; step(s, 0);

        repeat (150) rand_step();
        mid_reset();
        repeat (150) rand_step();

        repeat (2) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
